// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP pixel engine: mode codes, luma weights,
// FSM states and row stride/padding derivation.
package bmp_pkg;

  localparam logic [1:0] MODE_GRAY   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;
  localparam logic [1:0] MODE_COPY   = 2'd3;

  localparam int unsigned LUMA_W_B = 29;
  localparam int unsigned LUMA_W_G = 150;
  localparam int unsigned LUMA_W_R = 77;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PIX_RD,
    ST_PIX_CALC,
    ST_PIX_WR,
    ST_PAD_WR,
    ST_DONE
  } state_t;

  function automatic int calc_stride(input int img_width);
    return ((3 * img_width + 3) / 4) * 4;
  endfunction

  function automatic int calc_pad(input int img_width);
    return calc_stride(img_width) - 3 * img_width;
  endfunction

endpackage

// File: rtl/bmp_pixel_engine_if.sv
// Byte-wide ROM read port and RAM write port between the engine and the BMP memories.
interface bmp_pixel_engine_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 20
) ();

  logic [BYTE_WIDTH-1:0] ROM_Q;
  logic                  ROM_valid;
  logic [ADDR_WIDTH-1:0] ROM_addr;
  logic                  RAM_valid;
  logic [BYTE_WIDTH-1:0] RAM_D;
  logic [ADDR_WIDTH-1:0] RAM_addr;

  modport master (
    input  ROM_Q,
    output ROM_valid, ROM_addr, RAM_valid, RAM_D, RAM_addr
  );

  modport slave (
    output ROM_Q,
    input  ROM_valid, ROM_addr, RAM_valid, RAM_D, RAM_addr
  );

endinterface

// File: rtl/bmp_pixel_alu.sv
// Combinational per-pixel transform: gray, invert, threshold or copy of one BGR triple.
module bmp_pixel_alu
  import bmp_pkg::*;
(
  input  logic [7:0] b,
  input  logic [7:0] g,
  input  logic [7:0] r,
  input  logic [1:0] mode,
  input  logic [7:0] threshold,
  output logic [7:0] o0,
  output logic [7:0] o1,
  output logic [7:0] o2
);

  logic [16:0] sum;
  logic [7:0]  luma;
  logic [7:0]  bin;

  always_comb begin
    // weights total 256, so the top byte of the sum never exceeds 255
    sum  = 17'(LUMA_W_B) * 17'(b) + 17'(LUMA_W_G) * 17'(g) + 17'(LUMA_W_R) * 17'(r);
    luma = 8'(sum >> 8);
    bin  = (luma >= threshold) ? 8'hFF : 8'h00;
    o0   = b;
    o1   = g;
    o2   = r;
    unique case (mode)
      MODE_GRAY:   begin o0 = luma;     o1 = luma;     o2 = luma;     end
      MODE_INVERT: begin o0 = ~b;       o1 = ~g;       o2 = ~r;       end
      MODE_THRESH: begin o0 = bin;      o1 = bin;      o2 = bin;      end
      default:     begin o0 = b;        o1 = g;        o2 = r;        end
    endcase
  end

endmodule

// File: rtl/bmp_pixel_engine.sv
// Streams a 24-bit BMP from ROM to RAM: header copied, pixels transformed, row padding zeroed.
//  state    | meaning
//  IDLE     | wait for in_valid, latch mode/threshold
//  HDR      | pipelined header copy, RAM write lags ROM read by one byte
//  PIX_RD   | read B, G, R of one pixel
//  PIX_CALC | capture R, register transformed bytes
//  PIX_WR   | write three transformed bytes
//  PAD_WR   | write zero padding at end of row
//  DONE     | done high until in_valid drops
module bmp_pixel_engine
  import bmp_pkg::*;
#(
  parameter int BYTE_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 20,
  parameter int HEADER_SIZE = 54,
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [7:0] threshold,
  output logic       done,
  bmp_pixel_engine_if.master mem
);

  localparam int PAD   = calc_pad(IMG_WIDTH);
  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam logic [ADDR_WIDTH-1:0] HDR_END = ADDR_WIDTH'(HEADER_SIZE);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [1:0]            k, k_nxt;
  logic [COL_W-1:0]      col, col_nxt;
  logic [ROW_W-1:0]      row, row_nxt;
  logic [1:0]            mode_q, mode_nxt;
  logic [7:0]            thr_q, thr_nxt;
  logic [BYTE_WIDTH-1:0] b_q, b_nxt, g_q, g_nxt;
  logic [BYTE_WIDTH-1:0] o0_q, o0_nxt, o1_q, o1_nxt, o2_q, o2_nxt;
  logic [7:0]            alu_o0, alu_o1, alu_o2;

  bmp_pixel_alu u_alu (
    .b         (b_q),
    .g         (g_q),
    .r         (mem.ROM_Q),
    .mode      (mode_q),
    .threshold (thr_q),
    .o0        (alu_o0),
    .o1        (alu_o1),
    .o2        (alu_o2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      k      <= '0;
      col    <= '0;
      row    <= '0;
      mode_q <= '0;
      thr_q  <= '0;
      b_q    <= '0;
      g_q    <= '0;
      o0_q   <= '0;
      o1_q   <= '0;
      o2_q   <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      k      <= k_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      mode_q <= mode_nxt;
      thr_q  <= thr_nxt;
      b_q    <= b_nxt;
      g_q    <= g_nxt;
      o0_q   <= o0_nxt;
      o1_q   <= o1_nxt;
      o2_q   <= o2_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    k_nxt         = k;
    col_nxt       = col;
    row_nxt       = row;
    mode_nxt      = mode_q;
    thr_nxt       = thr_q;
    b_nxt         = b_q;
    g_nxt         = g_q;
    o0_nxt        = o0_q;
    o1_nxt        = o1_q;
    o2_nxt        = o2_q;
    mem.ROM_valid = 1'b0;
    mem.ROM_addr  = '0;
    mem.RAM_valid = 1'b0;
    mem.RAM_D     = '0;
    mem.RAM_addr  = '0;
    done          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          mode_nxt  = mode;
          thr_nxt   = threshold;
          ptr_nxt   = '0;
          k_nxt     = '0;
          col_nxt   = COL_W'(IMG_WIDTH - 1);
          row_nxt   = ROW_W'(IMG_HEIGHT - 1);
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        mem.ROM_valid = (ptr != HDR_END);
        mem.ROM_addr  = ptr;
        if (ptr != '0) begin
          mem.RAM_valid = 1'b1;
          mem.RAM_addr  = ptr - ADDR_WIDTH'(1);
          mem.RAM_D     = mem.ROM_Q;
        end
        // ptr is left at HEADER_SIZE, the first pixel byte
        if (ptr == HDR_END) state_nxt = ST_PIX_RD;
        else                ptr_nxt   = ptr + ADDR_WIDTH'(1);
      end
      ST_PIX_RD: begin
        mem.ROM_valid = 1'b1;
        mem.ROM_addr  = ptr + ADDR_WIDTH'(k);
        if (k == 2'd1) b_nxt = mem.ROM_Q;
        if (k == 2'd2) begin
          g_nxt     = mem.ROM_Q;
          k_nxt     = '0;
          state_nxt = ST_PIX_CALC;
        end else begin
          k_nxt = k + 2'd1;
        end
      end
      ST_PIX_CALC: begin
        o0_nxt    = alu_o0;
        o1_nxt    = alu_o1;
        o2_nxt    = alu_o2;
        state_nxt = ST_PIX_WR;
      end
      ST_PIX_WR: begin
        mem.RAM_valid = 1'b1;
        mem.RAM_addr  = ptr + ADDR_WIDTH'(k);
        case (k)
          2'd0:    mem.RAM_D = o0_q;
          2'd1:    mem.RAM_D = o1_q;
          default: mem.RAM_D = o2_q;
        endcase
        if (k == 2'd2) begin
          k_nxt   = '0;
          ptr_nxt = ptr + ADDR_WIDTH'(3);
          if (col != '0) begin
            col_nxt   = col - COL_W'(1);
            state_nxt = ST_PIX_RD;
          end else begin
            col_nxt = COL_W'(IMG_WIDTH - 1);
            if (PAD > 0)        state_nxt = ST_PAD_WR;
            else if (row == '0) state_nxt = ST_DONE;
            else begin
              row_nxt   = row - ROW_W'(1);
              state_nxt = ST_PIX_RD;
            end
          end
        end else begin
          k_nxt = k + 2'd1;
        end
      end
      ST_PAD_WR: begin
        mem.RAM_valid = 1'b1;
        mem.RAM_addr  = ptr + ADDR_WIDTH'(k);
        if (k == 2'(PAD - 1)) begin
          k_nxt   = '0;
          ptr_nxt = ptr + ADDR_WIDTH'(PAD);
          if (row == '0) state_nxt = ST_DONE;
          else begin
            row_nxt   = row - ROW_W'(1);
            state_nxt = ST_PIX_RD;
          end
        end else begin
          k_nxt = k + 2'd1;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!in_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bmp_pixel_engine.sv
// Self-checking bench: small random BMP images through the engine, compared against an offset-based reference model.
module tb_bmp_pixel_engine;

  localparam int HS        = 54;
  localparam int W         = 5;
  localparam int H         = 3;
  localparam int ROW_BYTES = 3 * W;
  localparam int STRIDE    = ((ROW_BYTES + 3) / 4) * 4;
  localparam int PADB      = STRIDE - ROW_BYTES;
  localparam int FILE      = HS + H * STRIDE;
  localparam int LAT       = 1 + HS + 1 + H * (7 * W + PADB);

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic       done;
  logic       clr_req;

  logic [7:0] rom [FILE];
  logic [7:0] ram [FILE];
  int n_cmp, n_bad;
  int act_cnt, ovl_cnt, oob_cnt;

  bmp_pixel_engine_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) bus ();

  bmp_pixel_engine #(
    .BYTE_WIDTH (8),
    .ADDR_WIDTH (20),
    .HEADER_SIZE(HS),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .threshold (threshold),
    .done      (done),
    .mem       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    act_cnt = 0;
    ovl_cnt = 0;
    oob_cnt = 0;
  end

  // ROM with one cycle read latency, RAM with synchronous write, plus bus monitors
  always @(posedge clk) begin
    if (bus.ROM_valid)
      bus.ROM_Q <= (int'(bus.ROM_addr) < FILE) ? rom[int'(bus.ROM_addr)] : 8'h00;
    if (clr_req) begin
      for (int i = 0; i < FILE; i++) ram[i] <= 8'hEE;
    end else if (bus.RAM_valid) begin
      if (int'(bus.RAM_addr) < FILE) ram[int'(bus.RAM_addr)] <= bus.RAM_D;
      else oob_cnt <= oob_cnt + 1;
    end
    if (bus.ROM_valid || bus.RAM_valid) act_cnt <= act_cnt + 1;
    if (bus.ROM_valid && bus.RAM_valid && (bus.RAM_addr + 20'd1 != bus.ROM_addr))
      ovl_cnt <= ovl_cnt + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int i, input logic [1:0] md, input logic [7:0] th);
    int rel, off, p, y;
    int px [3];
    if (i < HS) return rom[i];
    rel = i - HS;
    off = rel % STRIDE;
    if (off >= ROW_BYTES) return 8'h00;
    p = HS + (rel / STRIDE) * STRIDE + (off / 3) * 3;
    px[0] = int'(rom[p]);
    px[1] = int'(rom[p + 1]);
    px[2] = int'(rom[p + 2]);
    y = (29 * px[0] + 150 * px[1] + 77 * px[2]) / 256;
    case (md)
      2'd0:    return 8'(y);
      2'd1:    return 8'(255 - px[off % 3]);
      2'd2:    return (y >= int'(th)) ? 8'hFF : 8'h00;
      default: return 8'(px[off % 3]);
    endcase
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < FILE; i++) rom[i] = 8'($urandom);
  endtask

  task automatic set_px(input int idx, input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
    int p;
    p = HS + (idx / W) * STRIDE + 3 * (idx % W);
    rom[p] = b;
    rom[p + 1] = g;
    rom[p + 2] = r;
  endtask

  task automatic clear_ram();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic run_img(input logic [1:0] md, input logic [7:0] th, input bit hold, input bit noisy);
    int cyc, ovl0, oob0, snap;
    clear_ram();
    ovl0 = ovl_cnt;
    oob0 = oob_cnt;
    mode = md;
    threshold = th;
    in_valid = 1'b1;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check_val("start_rom_valid", int'(bus.ROM_valid), 1);
        check_val("start_rom_addr", int'(bus.ROM_addr), 0);
      end
      if (done || cyc > LAT + 20) break;
      @(negedge clk);
      if (!hold) in_valid = (noisy && cyc < LAT - 20) ? 1'($urandom) : 1'b0;
      if (noisy) begin
        mode = 2'($urandom);
        threshold = 8'($urandom);
      end
    end
    check_val("done_latency", cyc, LAT);
    if (hold) begin
      snap = act_cnt;
      repeat (8) @(negedge clk);
      check_val("hold_done_high", int'(done), 1);
      check_val("hold_bus_quiet", act_cnt - snap, 0);
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("done_clear", int'(done), 0);
    for (int i = 0; i < FILE; i++)
      check_val($sformatf("img[%0d]", i), int'(ram[i]), int'(ref_byte(i, md, th)));
    check_val("ram_out_of_range", oob_cnt - oob0, 0);
    check_val("rom_ram_overlap", ovl_cnt - ovl0, 0);
    @(negedge clk);
  endtask

  task automatic abort_run();
    int snap;
    @(negedge clk);
    mode = 2'd3;
    in_valid = 1'b1;
    repeat (121) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort_rom_valid", int'(bus.ROM_valid), 0);
    check_val("abort_ram_valid", int'(bus.RAM_valid), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_rom_addr", int'(bus.ROM_addr), 0);
    check_val("abort_ram_addr", int'(bus.RAM_addr), 0);
    check_val("abort_ram_d", int'(bus.RAM_D), 0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = act_cnt;
    repeat (4) @(negedge clk);
    check_val("abort_idle_quiet", act_cnt - snap, 0);
    check_val("abort_idle_done", int'(done), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    mode = 2'd0;
    threshold = 8'd0;
    clr_req = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rom_valid", int'(bus.ROM_valid), 0);
    check_val("rst_ram_valid", int'(bus.RAM_valid), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_rom_addr", int'(bus.ROM_addr), 0);
    check_val("rst_ram_addr", int'(bus.RAM_addr), 0);
    check_val("rst_ram_d", int'(bus.RAM_D), 0);
    rst_n = 1'b1;

    fill_rom();
    set_px(0, 8'd200, 8'd50, 8'd100);
    set_px(1, 8'd255, 8'd255, 8'd255);
    run_img(2'd0, 8'd0, 1'b0, 1'b0);
    check_val("gray_px0_o0", int'(ram[HS]), 82);
    check_val("gray_px0_o2", int'(ram[HS + 2]), 82);
    check_val("gray_px1_o1", int'(ram[HS + 4]), 255);
    check_val("gray_pad_row0", int'(ram[HS + ROW_BYTES]), 0);
    check_val("gray_hdr0", int'(ram[0]), int'(rom[0]));

    fill_rom();
    set_px(0, 8'd0, 8'd128, 8'd255);
    run_img(2'd1, 8'd0, 1'b0, 1'b0);
    check_val("inv_o0", int'(ram[HS]), 255);
    check_val("inv_o1", int'(ram[HS + 1]), 127);
    check_val("inv_o2", int'(ram[HS + 2]), 0);
    check_val("inv_pad_row1", int'(ram[HS + STRIDE + ROW_BYTES]), 0);

    fill_rom();
    set_px(0, 8'd200, 8'd50, 8'd100);
    run_img(2'd2, 8'd82, 1'b0, 1'b0);
    check_val("thr82_o0", int'(ram[HS]), 255);
    check_val("thr82_o2", int'(ram[HS + 2]), 255);
    run_img(2'd2, 8'd83, 1'b0, 1'b0);
    check_val("thr83_o0", int'(ram[HS]), 0);
    check_val("thr83_o2", int'(ram[HS + 2]), 0);

    fill_rom();
    run_img(2'd3, 8'd0, 1'b1, 1'b1);

    for (int n = 0; n < 6; n++) begin
      fill_rom();
      run_img(2'($urandom_range(0, 3)), 8'($urandom), 1'(n % 2), 1'b1);
    end

    fill_rom();
    abort_run();
    fill_rom();
    run_img(2'd0, 8'd100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bmp_pixel_engine.md
# bmp_pixel_engine

Parametrised successor to the BGR-to-gray converter. The block streams a 24-bit BMP image from the byte-wide BMP ROM into the single-port BMP RAM. It copies the header unchanged, transforms every pixel according to a run-time mode (gray, invert, threshold, copy) and writes row padding as zero. It sits between `BMP_ROM` and `BMP_SINGLE_PORT_RAM` and is started and monitored by the testbench via `in_valid`/`done`.

## Interface
- `BYTE_WIDTH`, 8: ROM/RAM data width; fixed at 8 for BMP.
- `ADDR_WIDTH`, 20: ROM/RAM byte address width.
- `HEADER_SIZE`, 54: header bytes copied verbatim.
- `IMG_WIDTH`, 512: pixels per row.
- `IMG_HEIGHT`, 512: rows.
- Derived: `ROW_BYTES = 3*IMG_WIDTH`; `STRIDE = ((ROW_BYTES+3)/4)*4`; `PAD = STRIDE-ROW_BYTES` (0..3).
- `clk  in  1  clock; all logic on posedge.`
- `rst_n  in  1  reset; one clock, synchronous, active-low.`
- `in_valid  in  1  start request; sampled in IDLE only.`
- `mode  in  2  0=gray, 1=invert, 2=threshold, 3=copy; latched at start.`
- `threshold  in  8  threshold level for mode 2; latched at start.`
- `ROM_Q  in  BYTE_WIDTH  ROM read data, valid 1 cycle after ROM_valid.`
- `ROM_valid  out  1  ROM read enable.`
- `ROM_addr  out  ADDR_WIDTH  ROM byte address.`
- `RAM_valid  out  1  RAM write enable.`
- `RAM_D  out  BYTE_WIDTH  RAM write data.`
- `RAM_addr  out  ADDR_WIDTH  RAM byte address.`
- `done  out  1  high while in DONE.`

## Operation
- States: IDLE, HDR, PIX_RD, PIX_CALC, PIX_WR, PAD_WR, DONE.
- IDLE: when `in_valid`=1, latch `mode`/`threshold`, clear counters, go to HDR.
- HDR: pipelined copy. Read address a in cycle t; write `ROM_Q` to RAM address a in cycle t+1. After the last header write, go to PIX_RD.
- PIX_RD: 3 cycles reading B, G, R at p, p+1, p+2. Capture B and G as they return. Go to PIX_CALC.
- PIX_CALC: capture R and compute outputs (o0, o1, o2) for (B, G, R):
  - gray: Y=(29·B+150·G+77·R)>>8, using a 17-bit sum. The weights total 256, so Y≤255 with no saturation. Output Y,Y,Y.
  - invert: 255-B, 255-G, 255-R.
  - threshold: (Y≥threshold)?255:0, applied to all three bytes.
  - copy: B, G, R.
- PIX_WR: 3 cycles writing o0, o1, o2 to p, p+1, p+2. Then:
  - next pixel in the row → PIX_RD;
  - end of row with PAD>0 → PAD_WR;
  - end of row with PAD=0 → next row, or DONE after the last row.
- PAD_WR: PAD cycles writing 0x00 with no ROM read; then next row or DONE.
- DONE: `done`=1 and all enables 0. Go to IDLE when `in_valid`=0. If `in_valid` is still high, stay in DONE; no restart without a low phase.
- `in_valid`, `mode` and `threshold` changes while busy are ignored.
- ROM and RAM are never both addressed in the same cycle by different transactions. Exception: in HDR the RAM write lags the ROM read by one address.

## Timing
- Reset (sync, `rst_n`=0 at posedge): state=IDLE; `ROM_valid`, `RAM_valid`, `done`=0; `ROM_addr`, `RAM_addr`, `RAM_D`=0; counters 0.
- Reset mid-run aborts immediately; RAM contents already written stay.
- ROM read latency is exactly 1 cycle.
- HDR lasts HEADER_SIZE+1 cycles.
- Per pixel: 7 cycles (3 RD, 1 CALC, 3 WR). Per row: 7·IMG_WIDTH+PAD cycles.
- Start-to-`done`: 1 (IDLE→HDR) + HEADER_SIZE+1 + IMG_HEIGHT·(7·IMG_WIDTH+PAD) cycles.
- Default 512×512 image: 1+55+512·3584 = 1,835,064 cycles.
- Addresses advance linearly: pixel bytes at HEADER_SIZE + row·STRIDE + 3·col + k.
- `done` rises on the clock edge that enters DONE and is registered (no combinational path from inputs).

## Structure
- Shared package `bmp_pkg`:
  - mode encoding constants;
  - luma weights 29/150/77;
  - state enum;
  - STRIDE/PAD derivation function.
- One sub-module: `bmp_pixel_alu`, a combinational block taking (B, G, R, mode, threshold) and producing (o0, o1, o2). It is instantiated once and registered in PIX_CALC.
- The top level holds the FSM, address/column/row counters and ROM/RAM handshaking.

## Test plan
- Gray, 4×1 image, pixel B=200, G=50, R=100 → RAM bytes 82,82,82. Pixel 255,255,255 → 255. Pad bytes (PAD=0) absent. Header bytes equal ROM bytes.
- Invert, 1×2 image (PAD=1), pixel (0,128,255) → (255,127,0). Byte at offset HEADER_SIZE+3 of each row =0x00.
- Threshold=82 with the pixel above → 255,255,255. Threshold=83 → 0,0,0.
- Copy mode on the full 512×512 file → output file byte-identical to input. `done` exactly 1,835,064 cycles after start.
- Assert `rst_n`=0 for 1 cycle during the 10th pixel → next cycle all outputs 0, state IDLE. A fresh `in_valid` pulse restarts from address 0.
- Hold `in_valid`=1 through DONE → `done` stays 1 and no further ROM/RAM activity. Drop `in_valid` → `done`=0 next cycle. Changing `mode` mid-run has no effect.
